// File: rtl/cnn_argmax.sv
// -----------------------------------------------------------------------------
// cnn_argmax
//
// Classification stage after the conv+FC accelerator. It takes one set of
// NUM_CLASS signed FC scores over a valid/ready handshake and copies them into
// an internal buffer. It then scans the buffer one class per cycle to find the
// maximum score. The winning class index and its score are presented to the
// E203 register interface over a second valid/ready handshake.
//
// Ties resolve to the lowest index, because the compare is strictly greater.
// After the accept edge, upstream may change i_res freely; the scan reads only
// the buffer.
//
// Optional build macro: CNN_ARGMAX_MARGIN_EN
//   Adds the o_margin port and second-best tracking. o_margin is
//   best - second_best, unsigned and saturating. The scan is seeded with the
//   ordered pair (score0, score1) and starts at class 2, so latency is one
//   cycle shorter.
//
// Ports
//   i_clk         rising-edge system clock
//   i_rst_n       asynchronous active-low reset
//   i_pre_valid   upstream score set valid
//   o_pre_ready   block can accept a score set (IDLE only, low in reset)
//   i_res         NUM_CLASS x DATA_W two's-complement scores
//   o_post_valid  result valid (DONE)
//   i_post_ready  downstream takes the result
//   o_class       index of the maximum score
//   o_score       maximum score
//   o_margin      best - second best (only with CNN_ARGMAX_MARGIN_EN)
//   o_busy        high in SCAN or DONE
// -----------------------------------------------------------------------------
module cnn_argmax #(
    parameter int NUM_CLASS = 10,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pre_valid,
    output logic              o_pre_ready,
    input  logic [DATA_W-1:0] i_res [NUM_CLASS-1:0],
    output logic              o_post_valid,
    input  logic              i_post_ready,
    output logic [IDX_W-1:0]  o_class,
    output logic [DATA_W-1:0] o_score,
`ifdef CNN_ARGMAX_MARGIN_EN
    output logic [DATA_W-1:0] o_margin,
`endif
    output logic              o_busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
`ifdef CNN_ARGMAX_MARGIN_EN
    localparam int START_CNT = 2;
`else
    localparam int START_CNT = 1;
`endif
    // With the margin option and only two classes, the seed pair already
    // holds the full answer, so no scan cycles are needed.
    localparam bit DIRECT_DONE = (START_CNT >= NUM_CLASS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_W-1:0] buf_q [NUM_CLASS];
    logic        [IDX_W-1:0]  cnt_q;
    logic signed [DATA_W-1:0] best_val_q;
    logic        [IDX_W-1:0]  best_idx_q;
    logic        [IDX_W-1:0]  class_q;
    logic signed [DATA_W-1:0] score_q;

    logic                     accept;
    logic                     last_cmp;
    logic signed [DATA_W-1:0] cand;
    logic                     new_max;
    logic signed [DATA_W-1:0] best_val_nx;
    logic        [IDX_W-1:0]  best_idx_nx;
    logic signed [DATA_W-1:0] init_best;
    logic        [IDX_W-1:0]  init_idx;

`ifdef CNN_ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0] second_q;
    logic signed [DATA_W-1:0] second_nx;
    logic signed [DATA_W-1:0] init_second;
    logic        [DATA_W-1:0] margin_q;

    // Difference of two signed values as an unsigned saturating result.
    // Because best >= second, the result is never negative. Both clamps are
    // kept so the function stays safe if it is reused elsewhere.
    function automatic logic [DATA_W-1:0] sat_margin(
        input logic signed [DATA_W-1:0] hi,
        input logic signed [DATA_W-1:0] lo
    );
        logic signed [DATA_W+1:0] diff;
        diff = (DATA_W+2)'(hi) - (DATA_W+2)'(lo);
        if (diff < 0) begin
            return '0;
        end else if (diff > $signed({2'b00, {DATA_W{1'b1}}})) begin
            return '1;
        end else begin
            return diff[DATA_W-1:0];
        end
    endfunction
`endif

    assign o_pre_ready  = i_rst_n && (state_q == S_IDLE);
    assign accept       = i_pre_valid && o_pre_ready;
    assign last_cmp     = (state_q == S_SCAN) && (cnt_q == LAST_IDX);
    assign o_post_valid = (state_q == S_DONE);
    assign o_busy       = (state_q != S_IDLE);
    assign o_class      = class_q;
    assign o_score      = score_q;
`ifdef CNN_ARGMAX_MARGIN_EN
    assign o_margin     = margin_q;
`endif

    // Seed values taken straight from the input at the accept edge.
    always_comb begin
        init_best = $signed(i_res[0]);
        init_idx  = '0;
`ifdef CNN_ARGMAX_MARGIN_EN
        init_second = $signed(i_res[1]);
        if ($signed(i_res[1]) > $signed(i_res[0])) begin
            init_best   = $signed(i_res[1]);
            init_idx    = IDX_W'(1);
            init_second = $signed(i_res[0]);
        end
`endif
    end

    // One scan step: select buf[cnt] and fold it into the running best.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CLASS; i++) begin
            if (cnt_q == IDX_W'(i)) begin
                cand = buf_q[i];
            end
        end
        new_max     = (cand > best_val_q);
        best_val_nx = new_max ? cand  : best_val_q;
        best_idx_nx = new_max ? cnt_q : best_idx_q;
`ifdef CNN_ARGMAX_MARGIN_EN
        if (new_max) begin
            second_nx = best_val_q;
        end else if (cand > second_q) begin
            second_nx = cand;
        end else begin
            second_nx = second_q;
        end
`endif
    end

    // ---- control: state register ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = DIRECT_DONE ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_post_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---- datapath: buffer load, scan accumulate, result capture ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                buf_q[i] <= '0;
            end
            cnt_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            class_q    <= '0;
            score_q    <= '0;
`ifdef CNN_ARGMAX_MARGIN_EN
            second_q   <= '0;
            margin_q   <= '0;
`endif
        end else if (accept) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                buf_q[i] <= $signed(i_res[i]);
            end
            cnt_q      <= IDX_W'(START_CNT);
            best_val_q <= init_best;
            best_idx_q <= init_idx;
`ifdef CNN_ARGMAX_MARGIN_EN
            second_q   <= init_second;
`endif
            if (DIRECT_DONE) begin
                class_q <= init_idx;
                score_q <= init_best;
`ifdef CNN_ARGMAX_MARGIN_EN
                margin_q <= sat_margin(init_best, init_second);
`endif
            end
        end else if (state_q == S_SCAN) begin
            cnt_q      <= cnt_q + IDX_W'(1);
            best_val_q <= best_val_nx;
            best_idx_q <= best_idx_nx;
`ifdef CNN_ARGMAX_MARGIN_EN
            second_q   <= second_nx;
`endif
            // The result registers change only when the scan ends, so the
            // last result stays visible through IDLE and the next SCAN.
            if (last_cmp) begin
                class_q <= best_idx_nx;
                score_q <= best_val_nx;
`ifdef CNN_ARGMAX_MARGIN_EN
                margin_q <= sat_margin(best_val_nx, second_nx);
`endif
            end
        end
    end

endmodule

// File: tb/tb_cnn_argmax.sv
`timescale 1ns/1ps
module tb_cnn_argmax;
    localparam int NUM_CLASS = 10;
    localparam int DATA_W    = 32;
    localparam int IDX_W     = 4;
`ifdef CNN_ARGMAX_MARGIN_EN
    localparam int LAT = NUM_CLASS - 2;
`else
    localparam int LAT = NUM_CLASS - 1;
`endif
    localparam int NV = 8;

    logic              clk;
    logic              i_rst_n;
    logic              i_pre_valid;
    logic              o_pre_ready;
    logic [DATA_W-1:0] res [NUM_CLASS-1:0];
    logic              o_post_valid;
    logic              i_post_ready;
    logic [IDX_W-1:0]  o_class;
    logic [DATA_W-1:0] o_score;
    logic [DATA_W-1:0] o_margin;
    logic              o_busy;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] cur [NUM_CLASS-1:0];

    typedef struct packed {
        logic [NUM_CLASS-1:0][DATA_W-1:0] s;
        logic [IDX_W-1:0]                 cls;
        logic [DATA_W-1:0]                sc;
        logic [DATA_W-1:0]                mg;
        logic [3:0]                       hold;
    } vec_rec_t;

    vec_rec_t tbl [NV];

    cnn_argmax #(
        .NUM_CLASS(NUM_CLASS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_pre_valid (i_pre_valid),
        .o_pre_ready (o_pre_ready),
        .i_res       (res),
        .o_post_valid(o_post_valid),
        .i_post_ready(i_post_ready),
        .o_class     (o_class),
        .o_score     (o_score),
`ifdef CNN_ARGMAX_MARGIN_EN
        .o_margin    (o_margin),
`endif
        .o_busy      (o_busy)
    );

`ifndef CNN_ARGMAX_MARGIN_EN
    assign o_margin = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the first index holding the maximum value, and the margin
    // to the largest of the remaining scores (saturated to DATA_W bits).
    task automatic model(output int c, output logic [DATA_W-1:0] sc, output logic [DATA_W-1:0] mg);
        longint v [NUM_CLASS];
        longint sec;
        longint d;
        for (int i = 0; i < NUM_CLASS; i++) v[i] = longint'($signed(cur[i]));
        c = 0;
        for (int i = 0; i < NUM_CLASS; i++) if (v[i] > v[c]) c = i;
        sec = -(longint'(1) <<< 62);
        for (int i = 0; i < NUM_CLASS; i++) if (i != c && v[i] > sec) sec = v[i];
        d = v[c] - sec;
        if (d > 64'd4294967295) d = 64'd4294967295;
        sc = cur[c];
        mg = d[31:0];
    endtask

    // Counts edges from just after the accept edge until o_post_valid rises.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (o_post_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic send_and_check(input string tag, input int exp_cls, input logic [DATA_W-1:0] exp_sc,
                                  input logic [DATA_W-1:0] exp_mg, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " pre_ready"}, 64'(o_pre_ready), 64'(1));
        for (int i = 0; i < NUM_CLASS; i++) res[i] = cur[i];
        i_pre_valid  = 1'b1;
        i_post_ready = 1'b0;
        @(posedge clk); #1;
        i_pre_valid = 1'b0;
        for (int i = 0; i < NUM_CLASS; i++) res[i] = $urandom;
        check({tag, " busy"}, 64'(o_busy), 64'(1));
        wait_valid(lat);
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " class"}, 64'(o_class), 64'(exp_cls));
        check({tag, " score"}, 64'(o_score), 64'(exp_sc));
`ifdef CNN_ARGMAX_MARGIN_EN
        check({tag, " margin"}, 64'(o_margin), 64'(exp_mg));
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 64'(o_post_valid), 64'(1));
            check({tag, " hold class"}, 64'(o_class), 64'(exp_cls));
            check({tag, " hold score"}, 64'(o_score), 64'(exp_sc));
            check({tag, " hold pre_ready"}, 64'(o_pre_ready), 64'(0));
`ifdef CNN_ARGMAX_MARGIN_EN
            check({tag, " hold margin"}, 64'(o_margin), 64'(exp_mg));
`endif
        end
        i_post_ready = 1'b1;
        @(posedge clk); #1;
        i_post_ready = 1'b0;
        check({tag, " valid drop"}, 64'(o_post_valid), 64'(0));
        check({tag, " class retained"}, 64'(o_class), 64'(exp_cls));
        check({tag, " idle busy"}, 64'(o_busy), 64'(0));
    endtask

    initial begin
        int nv [NUM_CLASS];
        int ec;
        int lat;
        logic [DATA_W-1:0] es;
        logic [DATA_W-1:0] em;

        // ---- vector table ----
        for (int k = 0; k < NV; k++) tbl[k] = '0;
        for (int i = 0; i < NUM_CLASS; i++) tbl[0].s[i] = 32'(i * 100);
        tbl[0].cls = 4'd9; tbl[0].sc = 32'd900; tbl[0].mg = 32'd100; tbl[0].hold = 4'd0;
        nv = '{-100, -90, -80, -5, -70, -60, -50, -40, -30, -10};
        for (int i = 0; i < NUM_CLASS; i++) tbl[1].s[i] = nv[i];
        tbl[1].cls = 4'd3; tbl[1].sc = 32'hFFFF_FFFB; tbl[1].mg = 32'd5; tbl[1].hold = 4'd2;
        tbl[2].s[2] = 32'd50; tbl[2].s[7] = 32'd50;
        tbl[2].cls = 4'd2; tbl[2].sc = 32'd50; tbl[2].mg = 32'd0; tbl[2].hold = 4'd0;
        tbl[3].s[0] = 32'd10; tbl[3].s[1] = 32'd40; tbl[3].s[2] = 32'd25;
        tbl[3].cls = 4'd1; tbl[3].sc = 32'd40; tbl[3].mg = 32'd15; tbl[3].hold = 4'd1;
        for (int i = 0; i < NUM_CLASS; i++) tbl[4].s[i] = 32'h8000_0000;
        tbl[4].s[0] = 32'h7FFF_FFFF;
        tbl[4].cls = 4'd0; tbl[4].sc = 32'h7FFF_FFFF; tbl[4].mg = 32'hFFFF_FFFF; tbl[4].hold = 4'd0;
        for (int i = 0; i < NUM_CLASS; i++) tbl[5].s[i] = 32'h8000_0000;
        tbl[5].cls = 4'd0; tbl[5].sc = 32'h8000_0000; tbl[5].mg = 32'd0; tbl[5].hold = 4'd3;
        for (int i = 0; i < NUM_CLASS; i++) tbl[6].s[i] = 32'(-i);
        tbl[6].s[9] = 32'h7FFF_FFFF;
        tbl[6].cls = 4'd9; tbl[6].sc = 32'h7FFF_FFFF; tbl[6].mg = 32'h7FFF_FFFF; tbl[6].hold = 4'd0;
        for (int i = 0; i < NUM_CLASS; i++) tbl[7].s[i] = 32'd3;
        tbl[7].s[0] = 32'd9; tbl[7].s[1] = 32'd9;
        tbl[7].cls = 4'd0; tbl[7].sc = 32'd9; tbl[7].mg = 32'd0; tbl[7].hold = 4'd0;

        // ---- reset state ----
        i_rst_n = 1'b0; i_pre_valid = 1'b0; i_post_ready = 1'b0;
        for (int i = 0; i < NUM_CLASS; i++) res[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst pre_ready", 64'(o_pre_ready), 64'(0));
        check("rst post_valid", 64'(o_post_valid), 64'(0));
        check("rst class", 64'(o_class), 64'(0));
        check("rst score", 64'(o_score), 64'(0));
        check("rst busy", 64'(o_busy), 64'(0));
        check("rst margin", 64'(o_margin), 64'(0));
        @(negedge clk);
        i_rst_n = 1'b1;

        // ---- table-driven vectors ----
        for (int k = 0; k < NV; k++) begin
            for (int i = 0; i < NUM_CLASS; i++) cur[i] = tbl[k].s[i];
            send_and_check($sformatf("vec%0d", k), int'(tbl[k].cls), tbl[k].sc, tbl[k].mg, int'(tbl[k].hold));
        end

        // ---- backpressure with a second request waiting ----
        for (int i = 0; i < NUM_CLASS; i++) cur[i] = 32'(i * 100);
        @(negedge clk);
        check("bp pre_ready", 64'(o_pre_ready), 64'(1));
        for (int i = 0; i < NUM_CLASS; i++) res[i] = cur[i];
        i_pre_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_CLASS; i++) res[i] = (i == 4) ? 32'd1234 : 32'(i);
        wait_valid(lat);
        check("bp latency A", 64'(lat), 64'(LAT));
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            check("bp hold valid", 64'(o_post_valid), 64'(1));
            check("bp hold class", 64'(o_class), 64'(9));
            check("bp hold score", 64'(o_score), 64'(900));
            check("bp hold pre_ready", 64'(o_pre_ready), 64'(0));
`ifdef CNN_ARGMAX_MARGIN_EN
            check("bp hold margin", 64'(o_margin), 64'(100));
`endif
        end
        i_post_ready = 1'b1;
        @(posedge clk); #1;
        i_post_ready = 1'b0;
        check("bp taken valid", 64'(o_post_valid), 64'(0));
        check("bp taken pre_ready", 64'(o_pre_ready), 64'(1));
        check("bp not yet accepted", 64'(o_busy), 64'(0));
        @(posedge clk); #1;
        check("bp B accepted", 64'(o_busy), 64'(1));
        i_pre_valid = 1'b0;
        wait_valid(lat);
        check("bp latency B", 64'(lat), 64'(LAT));
        check("bp B class", 64'(o_class), 64'(4));
        check("bp B score", 64'(o_score), 64'(1234));
`ifdef CNN_ARGMAX_MARGIN_EN
        check("bp B margin", 64'(o_margin), 64'(1225));
`endif
        i_post_ready = 1'b1;
        @(posedge clk); #1;
        i_post_ready = 1'b0;
        check("bp B drop", 64'(o_post_valid), 64'(0));

        // ---- asynchronous reset in the 4th scan cycle ----
        @(negedge clk);
        for (int i = 0; i < NUM_CLASS; i++) res[i] = 32'(i * 100);
        i_pre_valid = 1'b1;
        @(posedge clk); #1;
        i_pre_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid rst post_valid", 64'(o_post_valid), 64'(0));
        check("mid rst class", 64'(o_class), 64'(0));
        check("mid rst score", 64'(o_score), 64'(0));
        check("mid rst busy", 64'(o_busy), 64'(0));
        check("mid rst pre_ready", 64'(o_pre_ready), 64'(0));
        check("mid rst margin", 64'(o_margin), 64'(0));
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        check("post rst pre_ready", 64'(o_pre_ready), 64'(1));
        check("post rst post_valid", 64'(o_post_valid), 64'(0));
        for (int i = 0; i < NUM_CLASS; i++) cur[i] = '0;
        cur[5] = 32'd77;
        send_and_check("rst recover", 5, 32'd77, 32'd77, 0);

        // ---- randomized sets against the reference model ----
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NUM_CLASS; i++)
                cur[i] = (r % 3 == 0) ? (32'($urandom_range(0, 4)) - 32'd2) : 32'($urandom);
            model(ec, es, em);
            send_and_check($sformatf("rnd%0d", r), ec, es, em, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case some wait never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cnn_argmax.md
Name: cnn_argmax

Overview:
- Classification stage directly downstream of the conv+FC accelerator top.
- Accepts the 10 FC output scores (32-bit signed) through a valid/ready handshake.
- Finds the maximum score sequentially, one class per cycle, and presents the predicted class index and its score to the E203 register interface through a second valid/ready handshake.

Parameters:
- NUM_CLASS, 10, number of scores per inference (≥2).
- DATA_W, 32, score width; two's-complement signed.
- IDX_W, 4, class index width; must satisfy 2^IDX_W ≥ NUM_CLASS.

Ports:
- i_clk  input  1  system clock; all logic rising-edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_pre_valid  input  1  upstream scores valid.
- o_pre_ready  output  1  block can accept a score set.
- i_res  input  DATA_W x NUM_CLASS (unpacked [NUM_CLASS-1:0])  FC scores.
- o_post_valid  output  1  result valid.
- i_post_ready  input  1  downstream accepts result.
- o_class  output  IDX_W  index of the maximum score.
- o_score  output  DATA_W  maximum score value.
- o_busy  output  1  high in SCAN or DONE.

Behaviour:
- Reset values: o_pre_ready=0 while i_rst_n low, then 1 (IDLE). o_post_valid=0, o_class=0, o_score=0, o_busy=0. Score buffer, index counter and best registers cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - o_pre_ready=1.
  - On i_pre_valid && o_pre_ready: latch all NUM_CLASS scores into the internal buffer.
  - Load best_val=i_res[0], best_idx=0, cnt=1; go to SCAN.
- SCAN:
  - o_pre_ready=0.
  - Each cycle compare buf[cnt] with best_val as signed values.
  - If buf[cnt] > best_val (strictly greater), update best_val and best_idx=cnt.
  - cnt increments. When cnt==NUM_CLASS-1 has been compared, go to DONE.
- DONE:
  - o_post_valid=1; o_class=best_idx; o_score=best_val.
  - Outputs held stable while i_post_ready=0.
  - On i_post_ready=1: o_post_valid drops on the next edge; go to IDLE.
- Latency: handshake accepted at edge E; o_post_valid rises at edge E+NUM_CLASS-1 (9 cycles for the default).
- Throughput: one score set per NUM_CLASS+1 cycles minimum. No accept in SCAN or DONE.
- Ties: lowest index wins (strict compare).
- Upstream i_res may change after the accept edge; only the buffer is used.
- Asynchronous reset mid-operation: immediate return to reset values; any partial scan is discarded; no o_post_valid glitch.
- o_class/o_score retain the last result in IDLE until the next DONE update.

Optional Feature:
- Macro: CNN_ARGMAX_MARGIN_EN.
- When defined:
  - Adds output port o_margin (DATA_W, unsigned saturating) = best_val - second_val.
  - The block tracks a second-best register during SCAN. On a new max, second takes the old best; else if buf[cnt] > second, second updates.
  - second_val is initialised from i_res[1] ordering at accept: best/second = max/min of scores 0 and 1; scan starts at cnt=2.
  - Tie for max gives margin 0.
  - Result is clamped to 2^DATA_W-1 on overflow. Reset value 0; held with the other outputs in DONE.
  - Latency becomes NUM_CLASS-2 cycles.
- When undefined: no o_margin port, no second-best logic, timing as above.

Test Plan:
- Scores i*100 (0..900), i_post_ready=1 → o_class=9, o_score=900, o_post_valid for 1 cycle exactly 9 cycles after accept.
- All negative, score[3]=-5, others -100..-10 → o_class=3, o_score=-5 (0xFFFFFFFB).
- score[2]=score[7]=50, others 0 → o_class=2, o_score=50.
- Backpressure: i_post_ready=0 for 5 cycles in DONE → outputs stable, o_pre_ready=0, and a second i_pre_valid is not accepted until the result is taken.
- i_rst_n pulsed low in the 4th SCAN cycle → o_post_valid=0, o_class=0, o_busy=0 immediately; the next accepted set (max at index 5=77) gives o_class=5.
- With CNN_ARGMAX_MARGIN_EN, scores {10,40,25,0,...} → o_class=1, o_score=40, o_margin=15.
